// File: rtl/mem_pkg.sv
// Shared data-memory interface definitions: word width, default geometry,
// and the request/response records used by the CPU-side initiator, the
// memory responder and the cache fill logic.
package mem_pkg;

   localparam int MEM_DW         = 16;
   localparam int DEF_LATENCY    = 4;
   localparam int DEF_AW         = 16;
   localparam int DEF_WORDS_LOG2 = 15;

   typedef logic [MEM_DW-1:0] mem_word_t;

   // One request as presented by the initiator on a clock edge.
   typedef struct packed {
      logic              enable;
      logic              wr;
      logic [DEF_AW-1:0] addr;
      mem_word_t         data;
   } mem_req_t;

   // One completed read as seen by the initiator.
   typedef struct packed {
      logic              valid;
      mem_word_t         data;
      logic [DEF_AW-1:0] addr;
   } mem_resp_t;

   // Bits needed to count 0..latency outstanding reads.
   function automatic int cnt_width(input int latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// LATENCY-stage {valid, data, addr} shift pipeline carrying in-flight reads.
// Data and address registers only advance behind a valid bit, so the last
// stage keeps its previous response while no read completes.
module mem_resp_pipe
   import mem_pkg::*;
#(
   parameter int LATENCY = DEF_LATENCY,
   parameter int AW      = DEF_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  mem_word_t     in_data,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output mem_word_t     out_data,
   output logic [AW-1:0] out_addr
);

   logic          valid_q [LATENCY];
   mem_word_t     data_q  [LATENCY];
   logic [AW-1:0] addr_q  [LATENCY];

   // Shift reads one stage per cycle; async reset drops everything in flight.
   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its predecessor's pre-edge value, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
            addr_q[i]  <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            data_q[0] <= in_data;
            addr_q[0] <= in_addr;
         end
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               data_q[i] <= data_q[i-1];
               addr_q[i] <= addr_q[i-1];
            end
         end
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];
   assign out_addr  = addr_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency data-memory responder. Accepts one word request per cycle,
// writes at acceptance, and returns reads in order exactly LATENCY cycles
// after acceptance with a valid strobe and an address echo.
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY    = DEF_LATENCY,
   parameter int AW         = DEF_AW,
   parameter int WORDS_LOG2 = DEF_WORDS_LOG2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  mem_word_t     data_in,
   output mem_word_t     data_out,
   output logic          data_valid,
   output logic [AW-1:0] resp_addr,
   output logic          addr_err,
   output logic          busy
);

   localparam int CW    = cnt_width(LATENCY);
   localparam int DEPTH = 1 << WORDS_LOG2;

   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..8");
   end
   if (WORDS_LOG2 > AW - 1) begin : g_bad_depth
      $error("mem_responder: WORDS_LOG2 must not exceed AW-1");
   end

   mem_word_t             mem [DEPTH];
   logic [WORDS_LOG2-1:0] word_idx;
   logic [AW-1:0]         upper_bits;
   logic                  req_bad;
   logic                  rd_accept;
   logic                  wr_accept;
   mem_word_t             rd_data;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         outstanding_next;

   // A request is erroneous if it is misaligned or addresses beyond storage.
   assign word_idx   = addr[WORDS_LOG2:1];
   assign upper_bits = addr >> (WORDS_LOG2 + 1);
   assign req_bad    = addr[0] | (|upper_bits);

   assign rd_accept  = enable & ~wr;
   assign wr_accept  = enable & wr & ~req_bad;

   // Erroneous reads still complete, but carry zero instead of storage data.
   assign rd_data    = req_bad ? '0 : mem[word_idx];

   // Word storage, written at the accepting edge; erroneous writes are dropped.
   // NOTE: storage has no reset on purpose -- contents survive rst_n and the
   // array can map onto a RAM macro with no clear logic.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[word_idx] <= data_in;
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err <= 1'b0;
      end else if (enable && req_bad) begin
         addr_err <= 1'b1;
      end
   end

   // Outstanding-read count: +1 per accepted read, -1 per completed read.
   // NOTE: outstanding_next is assigned its hold value first, so every path
   // through the block drives it and no latch is inferred.
   always_comb begin
      outstanding_next = outstanding;
      case ({rd_accept, data_valid})
         2'b10:   outstanding_next = outstanding + CW'(1);
         2'b01:   outstanding_next = outstanding - CW'(1);
         default: outstanding_next = outstanding;
      endcase
   end

   // Outstanding counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_next;
      end
   end

   assign busy = (outstanding != '0);

   mem_resp_pipe #(
      .LATENCY (LATENCY),
      .AW      (AW)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_accept),
      .in_data   (rd_data),
      .in_addr   (addr),
      .out_valid (data_valid),
      .out_data  (data_out),
      .out_addr  (resp_addr)
   );

endmodule
